// File: rtl/bound_flasher_ctrl_pkg.sv
// Shared types and constants for the bound-flasher lamp bar controller.
// State encoding is exported on state_o, so keep it stable.
package bound_flasher_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } state_t;

  localparam int unsigned LVL_MAX   = 16;
  localparam int unsigned LVL_KICK  = 5;
  localparam int unsigned LVL_MID   = 11;
  localparam int unsigned LVL_LOW   = 6;
  localparam int unsigned LVL_ZERO  = 0;
  localparam int unsigned NUM_LAMPS = 16;

  function automatic int unsigned lvl_target(input state_t s);
    case (s)
      UP1:     return LVL_MAX;
      DN1:     return LVL_KICK;
      UP2:     return LVL_MID;
      UP3:     return LVL_LOW;
      default: return LVL_ZERO;
    endcase
  endfunction

  function automatic logic is_up(input state_t s);
    return (s == UP1) || (s == UP2) || (s == UP3);
  endfunction

endpackage

// File: rtl/bound_flasher_ctrl_if.sv
// Lamp-bar control bundle: flick request in, level/lamps/status out.
interface bound_flasher_ctrl_if #(
  parameter int IN_WIDTH  = 5,
  parameter int NUM_LAMPS = 16
);
  logic                 flick;
  logic [IN_WIDTH-1:0]  level;
  logic [NUM_LAMPS-1:0] lamps;
  logic                 busy;
  logic [2:0]           state_o;

  modport master (output flick, input level, lamps, busy, state_o);
  modport slave  (input flick, output level, lamps, busy, state_o);
endinterface

// File: rtl/bound_flasher_ctrl_decoder.sv
// Thermometer decoder: therm[i] = (i < code), purely combinational.
module decoder_under #(
  parameter int IN_WIDTH  = 5,
  parameter int OUT_WIDTH = 1 << IN_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  code,
  output logic [OUT_WIDTH-1:0] therm
);
  for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_bit
    localparam logic [IN_WIDTH:0] IDX = (IN_WIDTH + 1)'(gi);
    assign therm[gi] = ({1'b0, code} > IDX);
  end
endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher sequencer: ramps level through the flash pattern with
// kickback at the DN1/DN2 turning ticks; lamps are a thermometer of level.
module bound_flasher_ctrl #(
  parameter int IN_WIDTH  = 5,
  parameter int NUM_LAMPS = 16,
  parameter int STEP_DIV  = 1
) (
  input logic                 clk,
  input logic                 rst,
  bound_flasher_ctrl_if.slave bus
);
  import bound_flasher_pkg::*;

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_t              state_reg, state_next;
  logic [IN_WIDTH-1:0] level_reg, level_next;
  logic [IN_WIDTH-1:0] target;
  logic                busy_reg;
  logic [DIV_W-1:0]    div_reg;
  logic                tick;

  assign tick = (state_reg != IDLE) && (div_reg == DIV_W'(STEP_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      level_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  // A tick at the target is the dwell: level holds, only the state turns.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    target     = IN_WIDTH'(lvl_target(state_reg));
    if (state_reg == IDLE) begin
      level_next = '0;
      if (bus.flick) state_next = UP1;
    end else if (tick) begin
      if (level_reg != target) begin
        level_next = is_up(state_reg) ? level_reg + 1'b1 : level_reg - 1'b1;
      end else begin
        case (state_reg)
          UP1:     state_next = DN1;
          DN1:     state_next = bus.flick ? UP1 : UP2;
          UP2:     state_next = DN2;
          DN2:     state_next = bus.flick ? UP2 : UP3;
          UP3:     state_next = DN3;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign bus.level   = level_reg;
  assign bus.busy    = busy_reg;
  assign bus.state_o = state_reg;

  decoder_under #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (NUM_LAMPS)
  ) u_decoder (
    .code  (level_reg),
    .therm (bus.lamps)
  );
endmodule
